// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes and the mul/div unit state encoding.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_CALC   = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;
endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation; with neg = sign bit it yields the magnitude.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and restoring divide
// over unsigned magnitudes, with sign correction applied on the last step.
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_e         state;
  logic [4:0]        cnt;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   dvs;
  logic              neg_q, neg_r;

  // operand decode at start
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign is_div   = funct3[2];
  assign a_sgn    = is_div ? ~funct3[0] : (funct3 == F3_MULH || funct3 == F3_MULHSU);
  assign b_sgn    = is_div ? ~funct3[0] : (funct3 == F3_MULH);
  assign a_neg    = a_sgn & A[XLEN-1];
  assign b_neg    = b_sgn & B[XLEN-1];
  assign div_zero = is_div && (B == '0);
  assign div_ovf  = is_div && !funct3[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
  assign fast_res = div_zero ? (funct3[1] ? A : '1)
                             : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  muldiv_signfix #(.W(XLEN)) u_abs_a (.x(A), .neg(a_neg), .y(a_mag));
  muldiv_signfix #(.W(XLEN)) u_abs_b (.x(B), .neg(b_neg), .y(b_mag));

  // one iteration of either datapath
  logic [XLEN:0]     sum, part;
  logic [XLEN-1:0]   sub;
  logic              ge;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next;

  assign sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
  assign mul_next = {sum, acc[XLEN-1:1]};
  assign part     = acc[2*XLEN-1:XLEN-1];
  assign ge       = part >= {1'b0, dvs};
  assign sub      = part[XLEN-1:0] - dvs;
  assign div_next = ge ? {sub, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
  assign acc_next = op[2] ? div_next : mul_next;

  // final sign correction is taken from the last iteration's value
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  muldiv_signfix #(.W(2*XLEN)) u_fix_p (.x(acc_next), .neg(neg_q), .y(prod));
  muldiv_signfix #(.W(XLEN)) u_fix_q (.x(acc_next[XLEN-1:0]), .neg(neg_q), .y(quo));
  muldiv_signfix #(.W(XLEN)) u_fix_r (.x(acc_next[2*XLEN-1:XLEN]), .neg(neg_r), .y(rem));

  assign final_res = op[2] ? (op[1] ? rem : quo)
                           : ((op == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op     <= '0;
      acc    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        MD_IDLE, MD_FINISH: begin
          done <= 1'b0;
          if (start) begin
            op    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dvs   <= b_mag;
            acc   <= {{XLEN{1'b0}}, a_mag};
            cnt   <= '0;
            if (div_zero || div_ovf) begin
              result <= fast_res;
              done   <= 1'b1;
              state  <= MD_FINISH;
            end else begin
              busy  <= 1'b1;
              state <= MD_CALC;
            end
          end else begin
            state <= MD_IDLE;
          end
        end
        MD_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result <= final_res;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= MD_FINISH;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table of ops scored through an expected-result queue,
// plus hand sequences for ignored start, back-to-back issue and mid-op reset.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, busy, done;
  logic [2:0]  funct3;
  logic [31:0] A, B, result;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .A(A), .B(B), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    bit          fast;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          at;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: every done pops one expectation (value and cycle)
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, b, exp, input bit fast);
    @(negedge clk);
    start = 1'b1; funct3 = f3; A = a; B = b;
    sb_q.push_back('{exp, cyc + (fast ? 1 : 33)});
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; funct3 = 3'($urandom);
  endtask

  task automatic wait_drain(input int limit);
    for (int k = 0; k < limit && sb_q.size() != 0; k++) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: %0d results outstanding", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_op(input vec_t v);
    int nb, fb;
    drive(v.f3, v.a, v.b, v.exp, v.fast);
    nb = 0; fb = -1;
    for (int k = 1; k <= 40 && sb_q.size() != 0; k++) begin
      if (busy) begin nb++; if (fb < 0) fb = k; end
      @(negedge clk);
    end
    wait_drain(1);
    chk("busy_cycles", 32'(nb), v.fast ? 32'd0 : 32'd32);
    chk("busy_first", 32'(fb), v.fast ? 32'hFFFFFFFF : 32'd1);
    chk("done_pulse_end", {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0});
    vecs.push_back('{3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{3'b001, 32'hFFFFFFFE,  32'd3,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0});
    vecs.push_back('{3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{3'b101, 32'd100,       32'd7,        32'd14,       1'b0});
    vecs.push_back('{3'b111, 32'd100,       32'd7,        32'd2,        1'b0});
    vecs.push_back('{3'b101, 32'hFFFFFFFF,  32'h10000,    32'h0000FFFF, 1'b0});
    vecs.push_back('{3'b110, 32'd20,        32'hFFFFFFFA, 32'd2,        1'b0});
    vecs.push_back('{3'b100, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{3'b110, 32'd5,         32'd0,        32'd5,        1'b1});
    vecs.push_back('{3'b101, 32'd9,         32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{3'b111, 32'd9,         32'd0,        32'd9,        1'b1});
    vecs.push_back('{3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b1});
    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

    // start during CALC is dropped; spurious done would hit an empty queue
    drive(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (3) @(negedge clk);

    // back-to-back: second start in the FINISH cycle
    drive(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    repeat (32) @(negedge clk);
    chk("b2b_first_done", {31'b0, done}, 32'd1);
    start = 1'b1; funct3 = 3'b111; A = 32'd100; B = 32'd7;
    sb_q.push_back('{32'd2, cyc + 33});
    @(negedge clk);
    start = 1'b0;
    wait_drain(40);
    repeat (2) @(negedge clk);

    // asynchronous reset in cycle 10 of a DIVU
    begin
      bit seen;
      drive(3'b101, 32'd1000, 32'd3, 32'd333, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("abort_no_done", {31'b0, seen}, 32'd0);
    end
    run_op('{3'b000, 32'd3, 32'd4, 32'd12, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
